// File: rtl/shifter_barrel_pipe_pkg.sv
// Shared types for the pipelined barrel shifter: the operation encoding and its width.
package shifter_pkg;

  localparam int SHIFT_OP_W = 2;

  typedef enum logic [SHIFT_OP_W-1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shifter_barrel_pipe_if.sv
// Operand/result handshake bundle of the pipelined barrel shifter.
interface shifter_barrel_pipe_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int SHW   = $clog2(WIDTH)
);

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [SHIFT_OP_W-1:0] in_op_i;
  logic [SHW-1:0]        in_shamt_i;
  logic [WIDTH-1:0]      in_data_i;
  logic [TAG_W-1:0]      in_tag_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [WIDTH-1:0]      out_data_o;
  logic [TAG_W-1:0]      out_tag_o;

  modport master (
    output in_valid_i, in_op_i, in_shamt_i, in_data_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_tag_o
  );

  modport slave (
    input  in_valid_i, in_op_i, in_shamt_i, in_data_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_tag_o
  );

endinterface

// File: rtl/shifter_barrel_pipe_shift_level.sv
// One combinational barrel level: shifts or rotates by DIST when enabled, otherwise passes through.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  shift_op_e        op,
  input  logic             sign,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  // SRA fills from the operand's original MSB so every level extends the same sign
  always_comb begin
    result = data;
    if (en) begin
      case (op)
        SH_SLL:  result = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SH_SRL:  result = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
        SH_SRA:  result = {{DIST{sign}}, data[WIDTH-1:DIST]};
        SH_ROR:  result = {data[DIST-1:0], data[WIDTH-1:DIST]};
        default: result = data;
      endcase
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/shifter_barrel_pipe.sv
// Pipelined barrel shifter: one registered level per shamt bit (LSB level first) and a single
// advance enable that freezes every stage while the final result is back-pressured.
module shifter_barrel_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  shifter_barrel_pipe_if.slave bus
);

  typedef struct packed {
    shift_op_e        op;
    logic             sign;
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } stage_pay_t;

  logic             adv_s;
  logic             accept_s;
  logic [SHW-1:0]   valid_r;
  stage_pay_t       pay_r [SHW-1];
  logic [WIDTH-1:0] out_data_r;
  logic [TAG_W-1:0] out_tag_r;

  shift_op_e        lvl_op_s   [SHW];
  logic             lvl_sign_s [SHW];
  logic             lvl_en_s   [SHW];
  logic [WIDTH-1:0] lvl_in_s   [SHW];
  logic [TAG_W-1:0] lvl_tag_s  [SHW];
  logic [WIDTH-1:0] lvl_res_s  [SHW];

  assign adv_s           = !valid_r[SHW-1] || bus.out_ready_i;
  assign accept_s        = bus.in_valid_i && adv_s;
  assign bus.in_ready_o  = adv_s;
  assign bus.out_valid_o = valid_r[SHW-1];
  assign bus.out_data_o  = out_data_r;
  assign bus.out_tag_o   = out_tag_r;

  // Stage k keeps only the shamt bits still to be applied, right-aligned, so bit 0 drives level k+1
  for (genvar k = 0; k < SHW - 1; k++) begin : g_shamt
    logic [SHW-2-k:0] rem_r;
    if (k == 0) begin : g_head
      // Capture the upper shamt bits on acceptance-side advance
      always_ff @(posedge clk_i) begin
        if (adv_s) begin
          rem_r <= bus.in_shamt_i[SHW-1:1];
        end
      end
    end else begin : g_body
      // Drop the bit consumed by the previous level
      always_ff @(posedge clk_i) begin
        if (adv_s) begin
          rem_r <= g_shamt[k-1].rem_r[SHW-1-k:1];
        end
      end
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_level
    if (k == 0) begin : g_head
      assign lvl_op_s[k]   = shift_op_e'(bus.in_op_i);
      assign lvl_sign_s[k] = bus.in_data_i[WIDTH-1];
      assign lvl_en_s[k]   = bus.in_shamt_i[0];
      assign lvl_in_s[k]   = bus.in_data_i;
      assign lvl_tag_s[k]  = bus.in_tag_i;
    end else begin : g_body
      assign lvl_op_s[k]   = pay_r[k-1].op;
      assign lvl_sign_s[k] = pay_r[k-1].sign;
      assign lvl_en_s[k]   = g_shamt[k-1].rem_r[0];
      assign lvl_in_s[k]   = pay_r[k-1].data;
      assign lvl_tag_s[k]  = pay_r[k-1].tag;
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (2 ** k)
    ) u_level (
      .op     (lvl_op_s[k]),
      .sign   (lvl_sign_s[k]),
      .en     (lvl_en_s[k]),
      .data   (lvl_in_s[k]),
      .result (lvl_res_s[k])
    );
  end

  // Internal payload needs no reset: its validity is carried by valid_r
  always_ff @(posedge clk_i) begin
    if (adv_s) begin
      for (int k = 0; k < SHW - 1; k++) begin
        pay_r[k] <= '{op: lvl_op_s[k], sign: lvl_sign_s[k], data: lvl_res_s[k], tag: lvl_tag_s[k]};
      end
    end
  end

  // Valid chain and the output stage; a stall holds everything, a non-accept inserts a bubble
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r    <= '0;
      out_data_r <= '0;
      out_tag_r  <= '0;
    end else if (adv_s) begin
      valid_r    <= {valid_r[SHW-2:0], accept_s};
      out_data_r <= lvl_res_s[SHW-1];
      out_tag_r  <= lvl_tag_s[SHW-1];
    end
  end

endmodule

// File: tb/tb_shifter_barrel_pipe.sv
// Self-checking bench for shifter_barrel_pipe at WIDTH 32, 8 and 64 against an arithmetic model.
module tb_shifter_barrel_pipe;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  shifter_barrel_pipe_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
  shifter_barrel_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();
  shifter_barrel_pipe_if #(.WIDTH(64), .TAG_W(4)) bus64 ();

  shifter_barrel_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus32));
  shifter_barrel_pipe #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus8));
  shifter_barrel_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus64));

  // Reference: plain shift/rotate arithmetic on a w-bit value held in 64 bits
  function automatic logic [63:0] ref_shift(input int w, input logic [1:0] op, input int s,
                                            input logic [63:0] d);
    logic [63:0] mask, x, r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x = d & mask;
    case (op)
      2'd0: r = (x << s) & mask;
      2'd1: r = x >> s;
      2'd2: begin
        r = x >> s;
        if (x[w-1]) r = r | (mask & ~(mask >> s));
      end
      default: r = ((x >> s) | (x << (w - s))) & mask;
    endcase
    return r;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] op, input logic [6:0] sh,
                       input logic [63:0] d, input logic [3:0] tg, input logic ordy);
    case (sel)
      8: begin
        bus8.in_valid_i = v; bus8.in_op_i = op; bus8.in_shamt_i = sh[2:0];
        bus8.in_data_i = d[7:0]; bus8.in_tag_i = tg; bus8.out_ready_i = ordy;
      end
      32: begin
        bus32.in_valid_i = v; bus32.in_op_i = op; bus32.in_shamt_i = sh[4:0];
        bus32.in_data_i = d[31:0]; bus32.in_tag_i = tg; bus32.out_ready_i = ordy;
      end
      default: begin
        bus64.in_valid_i = v; bus64.in_op_i = op; bus64.in_shamt_i = sh[5:0];
        bus64.in_data_i = d; bus64.in_tag_i = tg; bus64.out_ready_i = ordy;
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic ov, output logic [63:0] od,
                        output logic [3:0] ot, output logic ir);
    case (sel)
      8: begin
        ov = bus8.out_valid_o; od = 64'(bus8.out_data_o); ot = bus8.out_tag_o; ir = bus8.in_ready_o;
      end
      32: begin
        ov = bus32.out_valid_o; od = 64'(bus32.out_data_o); ot = bus32.out_tag_o; ir = bus32.in_ready_o;
      end
      default: begin
        ov = bus64.out_valid_o; od = bus64.out_data_o; ot = bus64.out_tag_o; ir = bus64.in_ready_o;
      end
    endcase
  endtask

  task automatic test_reset();
    int sels [3] = '{8, 32, 64};
    logic ov, ir;
    logic [63:0] od;
    logic [3:0] ot;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    foreach (sels[i]) begin
      sample(sels[i], ov, od, ot, ir);
      checks++;
      if (ov !== 1'b0 || od !== 64'd0 || ot !== 4'd0 || ir !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold w=%0d: valid=%b data=%h tag=%0d ready=%b, expected 0/0/0/1",
                 sels[i], ov, od, ot, ir);
      end
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    foreach (sels[i]) begin
      sample(sels[i], ov, od, ot, ir);
      checks++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
        errors++;
        $display("FAIL reset_release w=%0d: valid=%b ready=%b, expected valid=0 ready=1",
                 sels[i], ov, ir);
      end
    end
  endtask

  task automatic test_ops_back_to_back();
    logic [31:0] exp_tab [4] = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h1800_000F};
    int acc_c [4];
    int got = 0;
    logic ov, ir;
    logic [63:0] od;
    logic [3:0] ot;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (c < 4) drive(32, 1'b1, c[1:0], 7'd4, 64'h8000_00F1, 4'(c + 9), 1'b1);
      else       drive(32, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b1);
      #1;
      sample(32, ov, od, ot, ir);
      if (ov) begin
        checks++;
        if (got >= 4) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result data=%h tag=%0d", od, ot);
        end else if (od !== 64'(exp_tab[got]) || ot !== 4'(got + 9) || cyc - acc_c[got] != 5) begin
          errors++;
          $display("FAIL b2b_op%0d: data=%h tag=%0d latency=%0d, expected data=%h tag=%0d latency=5",
                   got, od, ot, cyc - acc_c[got], exp_tab[got], got + 9);
        end
        got++;
      end
      if (c < 4) begin
        checks++;
        if (ir !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready c=%0d: ready=%b, expected 1", c, ir);
        end
        acc_c[c] = cyc;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, expected 4", got);
    end
  endtask

  task automatic test_edges();
    logic [31:0] exp_tab [8] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hBD5B_7DDF};
    int got = 0;
    logic ov, ir;
    logic [63:0] od;
    logic [3:0] ot;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (c < 8) drive(32, 1'b1, 2'(c % 4), (c < 4) ? 7'd0 : 7'd31, 64'hDEAD_BEEF, 4'(c + 1), 1'b1);
      else       drive(32, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b1);
      #1;
      sample(32, ov, od, ot, ir);
      if (ov) begin
        checks++;
        if (got >= 8) begin
          errors++;
          $display("FAIL edge_extra: unexpected result data=%h", od);
        end else if (od !== 64'(exp_tab[got]) || ot !== 4'(got + 1)) begin
          errors++;
          $display("FAIL edge_op%0d: data=%h tag=%0d, expected data=%h tag=%0d",
                   got, od, ot, exp_tab[got], got + 1);
        end
        got++;
      end
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL edge_count: got %0d results, expected 8", got);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_d [$];
    logic [3:0]  exp_t [$];
    logic [1:0]  op [8];
    int          sh [8];
    logic [31:0] d [8];
    logic ov, ir, ordy;
    logic [63:0] od, frz_d;
    logic [3:0] ot, frz_t;
    int idx = 0;
    int got = 0;
    frz_d = '0;
    frz_t = '0;
    for (int i = 0; i < 8; i++) begin
      op[i] = 2'($urandom_range(0, 3));
      sh[i] = $urandom_range(0, 31);
      d[i]  = $urandom();
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      ordy = !(c >= 6 && c < 12);
      if (idx < 8) drive(32, 1'b1, op[idx], 7'(sh[idx]), 64'(d[idx]), 4'(idx), ordy);
      else         drive(32, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, ordy);
      #1;
      sample(32, ov, od, ot, ir);
      if (c == 6) begin
        frz_d = od;
        frz_t = ot;
      end
      if (c > 6 && c < 12) begin
        checks++;
        if (od !== frz_d || ot !== frz_t || ir !== 1'b0 || ov !== 1'b1) begin
          errors++;
          $display("FAIL stall_freeze c=%0d: data=%h tag=%0d ready=%b valid=%b, expected data=%h tag=%0d ready=0 valid=1",
                   c, od, ot, ir, ov, frz_d, frz_t);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL stall_extra: unexpected result data=%h tag=%0d", od, ot);
        end else begin
          if (od !== exp_d[0] || ot !== exp_t[0]) begin
            errors++;
            $display("FAIL stall_order[%0d]: data=%h tag=%0d, expected data=%h tag=%0d",
                     got, od, ot, exp_d[0], exp_t[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_t.pop_front());
        end
        got++;
      end
      if (idx < 8 && ir) begin
        exp_d.push_back(ref_shift(32, op[idx], sh[idx], 64'(d[idx])));
        exp_t.push_back(4'(idx));
        idx++;
      end
    end
    checks++;
    if (got != 8 || idx != 8) begin
      errors++;
      $display("FAIL stall_count: sent %0d received %0d, expected 8 and 8", idx, got);
    end
  endtask

  task automatic test_bubbles();
    logic acc [40];
    logic ov, ir, v, exp_v;
    logic [63:0] od;
    logic [3:0] ot;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      v = (c % 2 == 0) && (c < 12);
      drive(32, v, 2'd1, 7'(c % 32), 64'h1234_5678, 4'(c), 1'b1);
      #1;
      sample(32, ov, od, ot, ir);
      acc[c] = v && ir;
      exp_v = 1'b0;
      if (c >= 5) exp_v = acc[c-5];
      checks++;
      if (ov !== exp_v) begin
        errors++;
        $display("FAIL bubble_valid c=%0d: valid=%b, expected %b", c, ov, exp_v);
      end
    end
  endtask

  task automatic test_random(input int sel, input int n);
    logic [63:0] exp_d [$];
    logic [3:0]  exp_t [$];
    int          exp_a [$];
    int shw = $clog2(sel);
    int sent = 0;
    int recv = 0;
    int adv_cnt = 0;
    int sh = 0;
    logic v, ordy;
    logic [1:0] op;
    logic [63:0] d, od;
    logic [3:0] tg, ot;
    logic ov, ir;
    v = 1'b0;
    op = 2'd0;
    d = '0;
    tg = '0;
    for (int c = 0; c < 3000 && !(sent == n && recv == n); c++) begin
      @(negedge clk_i);
      if (!v && sent < n && $urandom_range(0, 3) != 0) begin
        v = 1'b1;
        op = 2'($urandom_range(0, 3));
        sh = $urandom_range(0, sel - 1);
        d = {$urandom(), $urandom()};
        tg = 4'($urandom());
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive(sel, v, op, 7'(sh), d, tg, ordy);
      #1;
      sample(sel, ov, od, ot, ir);
      if (ov && ordy) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL rand_w%0d_extra: unexpected result data=%h", sel, od);
        end else begin
          if (od !== exp_d[0] || ot !== exp_t[0] || adv_cnt - exp_a[0] != shw) begin
            errors++;
            $display("FAIL rand_w%0d[%0d]: data=%h tag=%0d advances=%0d, expected data=%h tag=%0d advances=%0d",
                     sel, recv, od, ot, adv_cnt - exp_a[0], exp_d[0], exp_t[0], shw);
          end
          void'(exp_d.pop_front());
          void'(exp_t.pop_front());
          void'(exp_a.pop_front());
        end
        recv++;
      end
      if (v && ir) begin
        exp_d.push_back(ref_shift(sel, op, sh, d));
        exp_t.push_back(tg);
        exp_a.push_back(adv_cnt);
        sent++;
        v = 1'b0;
      end
      if (ir) adv_cnt++;
    end
    checks++;
    if (sent != n || recv != n) begin
      errors++;
      $display("FAIL rand_w%0d_timeout: sent %0d received %0d, expected %0d", sel, sent, recv, n);
    end
    @(negedge clk_i);
    drive(sel, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b1);
  endtask

  task automatic test_reset_midflight();
    logic ov, ir;
    logic [63:0] od;
    logic [3:0] ot;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (c < 3) drive(32, 1'b1, 2'd0, 7'd0, 64'hA5A5_0001, 4'(c + 5), 1'b0);
      else       drive(32, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b0);
      #1;
      sample(32, ov, od, ot, ir);
      if (c == 7) begin
        checks++;
        if (ov !== 1'b1 || od !== 64'hA5A5_0001) begin
          errors++;
          $display("FAIL midrst_before: valid=%b data=%h, expected valid=1 data=00000000a5a50001", ov, od);
        end
      end
    end
    rst_ni = 1'b0;
    #1;
    sample(32, ov, od, ot, ir);
    checks++;
    if (ov !== 1'b0 || od !== 64'd0 || ot !== 4'd0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b data=%h tag=%0d ready=%b, expected 0/0/0/1", ov, od, ot, ir);
    end
    #2;
    rst_ni = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_i);
      drive(32, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b1);
      #1;
      sample(32, ov, od, ot, ir);
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL midrst_emit c=%0d: valid=%b data=%h tag=%0d, expected no result", c, ov, od, ot);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(8,  1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b1);
    drive(32, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b1);
    drive(64, 1'b0, 2'd0, 7'd0, 64'd0, 4'd0, 1'b1);
    test_reset();
    test_ops_back_to_back();
    test_edges();
    test_backpressure();
    test_bubbles();
    test_random(32, 60);
    test_random(8, 60);
    test_random(64, 60);
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_barrel_pipe.md
# shifter_barrel_pipe

Parametrised, pipelined barrel shifter: the successor to the 16-bit combinational left/right shifter. It supports logical-left, logical-right, arithmetic-right and rotate-right on a WIDTH-bit operand. Each of the log2(WIDTH) shift levels is registered, and a valid/ready handshake carries a user tag alongside each operand. It sits between the ALU operand muxes and the writeback select. Throughput is one operation per cycle.

## Interface
Parameters:
- WIDTH, 32: operand width; power of two, 8..64.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.
- TAG_W, 4: width of the opaque tag carried with each operation.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  operation presented.
- in_ready_o  out  1  block can accept this cycle.
- in_op_i  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_shamt_i  in  SHW  shift amount, 0..WIDTH-1.
- in_data_i  in  WIDTH  source operand.
- in_tag_i  in  TAG_W  user tag, returned unchanged.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts result.
- out_data_o  out  WIDTH  shifted result.
- out_tag_o  out  TAG_W  tag of the operation in out_data_o.

## Operation
- The pipeline has SHW stages. Stage k (k=0..SHW-1) applies a shift of 2^k when shamt bit k = 1, and passes data through otherwise. Levels are ordered LSB first.
- Per-level operations:
  - SLL fills with 0 from the LSB side.
  - SRL fills with 0 from the MSB side.
  - SRA fills with the original operand MSB.
  - ROR wraps the low 2^k bits to the top.
- Each stage register holds valid, op, the remaining shamt bits, the sign bit (captured at stage 0), data and tag.
- The final stage register drives out_*_o directly. Outputs carry no combinational path from in_*_i.
- Global advance enable: adv = !out_valid_o || out_ready_i. in_ready_o = adv.
- Accept occurs when in_valid_i && in_ready_o. Stage 0 loads valid=1 plus the operands. When adv=1 and no accept, stage 0 loads valid=0, so bubbles flow.
- When adv=0, every stage holds all of its contents. Inputs are ignored and out_*_o stay stable.
- shamt=0 gives a result equal to in_data_i for all four ops.
- Results leave in acceptance order, one per cycle when not stalled.

## Timing
- Latency: an accept in cycle t yields out_valid_o=1 in cycle t+SHW, provided no stall occurs in between. Each stall cycle adds one cycle.
- Stall: out_valid_o=1 with out_ready_i=0 freezes the whole pipeline. in_ready_o drops combinationally in the same cycle.
- Out transfer and a new accept may happen in the same cycle.
- in_ready_o is combinational from out_ready_i and out_valid_o. There is no combinational path from in_valid_i to any output.
- Reset, asserted at any time, asynchronously clears:
  - every stage valid bit, so out_valid_o=0;
  - out_data_o=0 and out_tag_o=0.
- In-flight operations during reset are discarded and never emitted. in_ready_o=1 while rst_ni is low and after release.
- Data and tag registers in internal stages need no reset. Only valid bits and the output stage must be reset.

## Structure
- Package shifter_pkg holds:
  - typedef enum logic [1:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_ROR};
  - the stage-payload struct (op, sign, data, tag; parametrised through the module).
- Sub-module shift_level:
  - purely combinational, with parameters WIDTH and DIST (=2^k);
  - inputs op, sign, enable bit, data; output shifted data.
- The top generates SHW instances, each followed by the stage register and a common advance-enable.

## Test plan
- WIDTH=32, back-to-back accepts with out_ready_i=1, all four ops:
  - input 0x8000_00F1, shamt=4: SLL -> 0x0000_0F10, SRL -> 0x0800_000F, SRA -> 0xF800_000F, ROR -> 0x1800_000F.
  - Each result arrives exactly 5 cycles after its accept, and tags are preserved.
- shamt=0 and shamt=31 on 0xDEAD_BEEF:
  - shamt=0 passes unchanged for every op.
  - shamt=31: SLL -> 0x8000_0000, SRL -> 0x0000_0001, SRA -> 0xFFFF_FFFF, ROR -> 0xBD5B_7DDF.
- Backpressure:
  - Stream 8 ops with tags 0..7 and hold out_ready_i=0 for 6 cycles mid-stream.
  - out_data_o and out_tag_o stay frozen and in_ready_o=0 during the stall.
  - All 8 results emerge in order, with no loss and no duplication.
- Bubbles: accept only on alternate cycles -> out_valid_o toggles with the same spacing, shifted by 5 cycles.
- Reset mid-flight: with 3 ops in the pipeline, pulse rst_ni low for a half cycle -> out_valid_o=0 immediately, out_data_o=0, and none of the 3 ops is ever emitted.
- Parameter sweep WIDTH=8 and WIDTH=64:
  - Random ops are compared against a reference model.
  - Latency equals 3 and 6 cycles respectively.
